// File: rtl/mon_nchiq_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mon_nchiq_reset_pkg
// Brief    : Shared constants and helpers for the N-lane CIC amplitude monitor.
// Revision : 1.0 - initial release
// ============================================================================
package mon_nchiq_reset_pkg;

    localparam int MON_SCALE_W = 18;

    // Ceiling log2, usable in constant expressions for sizing.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mon_nchiq_reset_lane.sv
`default_nettype none
// ============================================================================
// Module   : double_inte_reset_lane
// Brief    : Order-2 integrator pair (acc1/acc2) with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
module double_inte_reset_lane #(
    parameter int DWA = 19,
    parameter int RWI = 28
) (
    input  logic                  clk,
    input  logic                  i_clr,
    input  logic signed [DWA-1:0] i_din,
    output logic signed [RWI-1:0] o_acc2
);

    logic signed [RWI-1:0] r_acc1;
    logic signed [RWI-1:0] r_acc2;
    logic signed [RWI-1:0] w_din_ext;

    assign w_din_ext = {{(RWI-DWA){i_din[DWA-1]}}, i_din};

    // Both stages wrap modulo 2^RWI; the CIC difference stage downstream relies on it.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_acc1 <= '0;
            r_acc2 <= '0;
        end else begin
            r_acc1 <= r_acc1 + w_din_ext;
            r_acc2 <= r_acc2 + r_acc1;
        end
    end

    assign o_acc2 = r_acc2;

endmodule
`default_nettype wire

// File: rtl/mon_nchiq_reset.sv
`default_nettype none
// ============================================================================
// Module   : mon_nchiq_reset
// Brief    : N-lane interleaved CIC amplitude monitor with lane-sync tracking
//            and a daisy-chained serial result stream.
// Revision : 1.0 - initial release
// ============================================================================
module mon_nchiq_reset
    import mon_nchiq_reset_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int DWI  = 16,
    parameter int RWI  = 28,
    parameter int DAVR = 3,
    parameter int LW   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DWI-1:0]         iqd,
    input  logic signed [MON_SCALE_W-1:0] scale,
    input  logic                          iqs,
    input  logic                          samp,
    input  logic signed [RWI-1:0]         s_in,
    input  logic                          g_in,
    output logic signed [RWI-1:0]         s_out,
    output logic                          g_out,
    output logic                          sync_err
);

    localparam int c_pw = DWI + MON_SCALE_W;
    localparam int c_sw = DWI + DAVR;
    localparam int c_lw = (LW > clog2(NCH)) ? LW : clog2(NCH);
    localparam logic [c_lw-1:0] c_last = c_lw'(NCH - 1);

    logic signed [c_pw-1:0] r_prod;
    logic signed [c_pw-1:0] r_prod2;
    logic signed [c_sw-1:0] w_scaled;
    logic [1:0]             r_iqs_pipe;
    logic [1:0]             r_rst_pipe;
    logic                   w_iqs_d;
    logic                   w_reset_d;
    logic                   w_unused_bits;

    always_ff @(posedge clk) begin
        r_prod     <= c_pw'(iqd) * c_pw'(scale);
        r_prod2    <= r_prod;
        r_iqs_pipe <= {r_iqs_pipe[0], iqs};
        r_rst_pipe <= {r_rst_pipe[0], reset};
    end

    // Truncating slice: drops the redundant top sign bit and keeps DAVR guard bits.
    assign w_scaled      = r_prod2[DWI+16 : 17-DAVR];
    assign w_unused_bits = ^{r_prod2[c_pw-1], r_prod2[16-DAVR:0]};
    assign w_iqs_d       = r_iqs_pipe[1];
    assign w_reset_d     = r_rst_pipe[1];

    logic [c_lw-1:0]        r_lane;
    logic [c_lw-1:0]        w_lane_pred;
    logic [c_lw-1:0]        w_lane;
    logic                   w_err;
    logic                   r_synced;
    logic                   r_sync_err;
    logic signed [c_sw-1:0] r_hold    [NCH];
    logic signed [c_sw-1:0] r_aligned [NCH];

    always_comb begin
        w_lane_pred = (r_lane == c_last) ? '0 : r_lane + c_lw'(1);
        w_lane      = w_iqs_d ? '0 : w_lane_pred;
        w_err       = r_synced &&
                      (( w_iqs_d && (w_lane_pred != '0)) ||
                       (!w_iqs_d && (w_lane_pred == '0)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                r_hold[k]    <= '0;
                r_aligned[k] <= '0;
            end
            r_lane     <= c_last;
            r_synced   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (w_lane == c_lw'(k)) begin
                    r_hold[k] <= w_scaled;
                end
            end
            // Whole frame moves to the integrators at once, on its last lane.
            if (w_lane == c_last) begin
                for (int k = 0; k < NCH - 1; k++) begin
                    r_aligned[k] <= r_hold[k];
                end
                r_aligned[NCH-1] <= w_scaled;
            end
            r_lane <= w_lane;
            if (w_iqs_d) begin
                r_synced <= 1'b1;
            end
            if (w_err) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    logic signed [RWI-1:0] w_acc2 [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        double_inte_reset_lane #(
            .DWA (c_sw),
            .RWI (RWI)
        ) u_inte (
            .clk    (clk),
            .i_clr  (w_reset_d),
            .i_din  (r_aligned[k]),
            .o_acc2 (w_acc2[k])
        );
    end

    logic signed [RWI-1:0] r_st      [NCH];
    logic signed [RWI-1:0] w_st_next [NCH];
    logic [NCH-1:0]        r_gt;
    logic [NCH-1:0]        w_gt_next;

    for (genvar k = 0; k < NCH; k++) begin : g_ser
        if (k == NCH - 1) begin : g_tail
            assign w_st_next[k] = s_in;
        end else begin : g_link
            assign w_st_next[k] = r_st[k+1];
        end
    end

    assign w_gt_next = {g_in, r_gt[NCH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                r_st[k] <= '0;
            end
            r_gt <= '0;
        end else if (samp) begin
            for (int k = 0; k < NCH; k++) begin
                r_st[k] <= w_acc2[k];
            end
            r_gt <= '1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                r_st[k] <= w_st_next[k];
            end
            r_gt <= w_gt_next;
        end
    end

    assign s_out    = r_st[0];
    assign g_out    = r_gt[0];
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire
